// File: rtl/fetch_pc_predictor.sv
// Fetch-stage next-PC selection with a 2-bit saturating-counter BHT.
// Execute-stage resolutions train the BHT, and a misprediction redirects fetch.
module fetch_pc_predictor #(
    parameter int          BHT_INDEX_SIZE = 10,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        BTBHit,
    input  logic [31:0] branchimmF,
    input  logic        resolveE,
    input  logic [31:0] pcE,
    input  logic        takenE,
    input  logic        predTakenE,
    input  logic [31:0] branchimmE,
    output logic [31:0] pcF,
    output logic        predTakenF,
    output logic        redirectE,
    output logic [31:0] mispredictCount
);

    localparam int BHT_ENTRIES = 1 << BHT_INDEX_SIZE;

    logic [1:0]                r_bht [BHT_ENTRIES];
    logic [31:0]               r_pc;
    logic [31:0]               r_mispredict_count;

    logic [BHT_INDEX_SIZE-1:0] w_fetch_idx;
    logic [BHT_INDEX_SIZE-1:0] w_resolve_idx;
    logic [1:0]                w_resolve_ctr;
    logic [31:0]               w_next_pc;

    assign w_fetch_idx   = r_pc[BHT_INDEX_SIZE+1:2];
    assign w_resolve_idx = pcE[BHT_INDEX_SIZE+1:2];
    assign w_resolve_ctr = r_bht[w_resolve_idx];

    assign predTakenF      = BTBHit & r_bht[w_fetch_idx][1];
    assign redirectE       = resolveE & (takenE != predTakenE);
    assign pcF             = r_pc;
    assign mispredictCount = r_mispredict_count;

    // A redirect from Execute outranks both the stall and the fetch-side prediction.
    always_comb begin
        // NOTE: default first so every path assigns w_next_pc and no latch is inferred.
        w_next_pc = r_pc + 32'd4;
        if (redirectE) begin
            w_next_pc = takenE ? (pcE + branchimmE) : (pcE + 32'd4);
        end else if (stallF) begin
            w_next_pc = r_pc;
        end else if (predTakenF) begin
            w_next_pc = r_pc + branchimmF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc               <= RESET_PC;
            r_mispredict_count <= 32'd0;
        end else begin
            r_pc <= w_next_pc;
            if (redirectE) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    // NOTE: the BHT has to come out of reset as weakly not-taken, so it is built
    // from resettable flops rather than an unreset RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (resolveE) begin
            if (takenE) begin
                if (w_resolve_ctr != 2'b11) begin
                    r_bht[w_resolve_idx] <= w_resolve_ctr + 2'd1;
                end
            end else if (w_resolve_ctr != 2'b00) begin
                r_bht[w_resolve_idx] <= w_resolve_ctr - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed testbench for fetch_pc_predictor.
// Expected values are hand-derived from the predictor's documented behaviour.
module tb_fetch_pc_predictor;

    logic        clk;
    logic        reset;
    logic        stallF;
    logic        BTBHit;
    logic [31:0] branchimmF;
    logic        resolveE;
    logic [31:0] pcE;
    logic        takenE;
    logic        predTakenE;
    logic [31:0] branchimmE;
    logic [31:0] pcF;
    logic        predTakenF;
    logic        redirectE;
    logic [31:0] mispredictCount;

    int n_tests;
    int n_fail;

    fetch_pc_predictor #(
        .BHT_INDEX_SIZE(10),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stallF         (stallF),
        .BTBHit         (BTBHit),
        .branchimmF     (branchimmF),
        .resolveE       (resolveE),
        .pcE            (pcE),
        .takenE         (takenE),
        .predTakenE     (predTakenE),
        .branchimmE     (branchimmE),
        .pcF            (pcF),
        .predTakenF     (predTakenF),
        .redirectE      (redirectE),
        .mispredictCount(mispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle outputs away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred,
                           input logic [31:0] imm);
        resolveE   = 1'b1;
        pcE        = pc;
        takenE     = taken;
        predTakenE = pred;
        branchimmE = imm;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        stallF     = 1'b0;
        BTBHit     = 1'b0;
        branchimmF = 32'h0;
        resolveE   = 1'b0;
        pcE        = 32'h0;
        takenE     = 1'b0;
        predTakenE = 1'b0;
        branchimmE = 32'h0;

        // Reset state
        #3;
        check("reset_pcF", pcF, 32'h0);
        check("reset_count", mispredictCount, 32'h0);
        check("reset_predTakenF", {31'b0, predTakenF}, 32'h0);
        check("reset_redirectE", {31'b0, redirectE}, 32'h0);

        // Release between edges; sequential fetch 0, 4, 8
        #9;
        reset = 1'b1;
        #1;
        check("seq_pc0", pcF, 32'h0);
        step();
        check("seq_pc4", pcF, 32'h4);
        step();
        check("seq_pc8", pcF, 32'h8);
        check("seq_pred", {31'b0, predTakenF}, 32'h0);
        check("seq_count", mispredictCount, 32'h0);

        for (int i = 0; i < 14; i++) step();
        check("seq_pc40", pcF, 32'h40);

        // BTB hit on an untrained entry predicts not-taken
        BTBHit     = 1'b1;
        branchimmF = 32'h100;
        #1;
        check("train_pred_cold", {31'b0, predTakenF}, 32'h0);
        step();
        check("train_pc44", pcF, 32'h44);

        // Train 0x40 twice taken (no redirect), holding fetch
        BTBHit = 1'b0;
        stallF = 1'b1;
        resolve(32'h40, 1'b1, 1'b1, 32'h0);
        #1;
        check("train_no_redirect", {31'b0, redirectE}, 32'h0);
        step();
        step();
        check("train_stall_hold", pcF, 32'h44);

        // Mispredicted not-taken at 0x3C redirects to 0x40
        stallF = 1'b0;
        resolve(32'h3C, 1'b0, 1'b1, 32'h0);
        #1;
        check("refetch_redirect", {31'b0, redirectE}, 32'h1);
        step();
        check("refetch_pc40", pcF, 32'h40);
        check("refetch_count1", mispredictCount, 32'h1);

        resolveE   = 1'b0;
        BTBHit     = 1'b1;
        branchimmF = 32'h100;
        #1;
        check("trained_pred", {31'b0, predTakenF}, 32'h1);
        step();
        check("trained_pc140", pcF, 32'h140);

        // Mispredict overrides stall; target wraps 0x40 + 0xFFFFFFF0 = 0x30
        BTBHit = 1'b0;
        stallF = 1'b1;
        resolve(32'h40, 1'b1, 1'b0, 32'hFFFF_FFF0);
        #1;
        check("stall_redirect", {31'b0, redirectE}, 32'h1);
        step();
        check("stall_redirect_pc30", pcF, 32'h30);
        check("stall_redirect_count2", mispredictCount, 32'h2);

        // Back to 0x40, then redirect and prediction in the same cycle
        stallF = 1'b0;
        resolve(32'h3C, 1'b0, 1'b1, 32'h0);
        step();
        check("back_pc40", pcF, 32'h40);
        BTBHit     = 1'b1;
        branchimmF = 32'h100;
        resolve(32'h200, 1'b0, 1'b1, 32'h0);
        #1;
        check("both_pred", {31'b0, predTakenF}, 32'h1);
        check("both_redirect", {31'b0, redirectE}, 32'h1);
        step();
        check("both_redirect_wins", pcF, 32'h204);
        check("both_count4", mispredictCount, 32'h4);

        // Saturation at 0x204 with fetch held on the same index
        stallF     = 1'b1;
        branchimmF = 32'h10;
        resolve(32'h204, 1'b1, 1'b1, 32'h0);
        #1;
        check("sat_old_value_read", {31'b0, predTakenF}, 32'h0);
        step();
        check("sat_t1_10", {31'b0, predTakenF}, 32'h1);
        step();
        step();
        step();
        check("sat_t4_11", {31'b0, predTakenF}, 32'h1);
        resolve(32'h204, 1'b0, 1'b0, 32'h0);
        step();
        check("sat_nt1_10", {31'b0, predTakenF}, 32'h1);
        step();
        check("sat_nt2_01", {31'b0, predTakenF}, 32'h0);
        step();
        step();
        step();
        check("sat_nt5_00", {31'b0, predTakenF}, 32'h0);
        resolve(32'h204, 1'b1, 1'b1, 32'h0);
        step();
        check("sat_floor_01", {31'b0, predTakenF}, 32'h0);
        step();
        check("sat_floor_10", {31'b0, predTakenF}, 32'h1);
        check("sat_no_miscount", mispredictCount, 32'h4);
        check("sat_pc_held", pcF, 32'h204);

        // Wrap-around: get to 0xFFFFFFFC via not-taken redirect
        BTBHit = 1'b0;
        resolve(32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0);
        step();
        check("wrap_pc_top", pcF, 32'hFFFF_FFFC);
        resolveE = 1'b0;
        stallF   = 1'b0;
        step();
        check("wrap_seq_zero", pcF, 32'h0);

        // Train 0xFFFFFFFC to strongly taken and return there
        stallF = 1'b1;
        resolve(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0);
        step();
        step();
        resolve(32'hFFFF_FFF8, 1'b0, 1'b1, 32'h0);
        step();
        check("wrap_back_top", pcF, 32'hFFFF_FFFC);
        check("wrap_count6", mispredictCount, 32'h6);
        resolveE   = 1'b0;
        stallF     = 1'b0;
        BTBHit     = 1'b1;
        branchimmF = 32'h8;
        #1;
        check("wrap_pred", {31'b0, predTakenF}, 32'h1);
        step();
        check("wrap_taken_pc4", pcF, 32'h4);

        // Async reset asserted mid-cycle while a redirect is pending
        BTBHit = 1'b0;
        resolve(32'h100, 1'b1, 1'b0, 32'h20);
        #1;
        check("areset_pending", {31'b0, redirectE}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("areset_pcF", pcF, 32'h0);
        check("areset_count", mispredictCount, 32'h0);
        resolveE = 1'b0;
        step();
        check("areset_hold_pc", pcF, 32'h0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) step();
        check("areset_pc40", pcF, 32'h40);
        BTBHit     = 1'b1;
        branchimmF = 32'h100;
        #1;
        check("areset_bht_cleared", {31'b0, predTakenF}, 32'h0);
        step();
        check("areset_seq_pc44", pcF, 32'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
